// File: rtl/led_frame_ctrl.sv
// led_frame_ctrl: double-buffered frame scanner that serialises CH grayscale channels to daisy-chained LED drivers.
// Optional macro LED_TEST_PATTERN_EN adds input i_test, which replaces memory data with a fixed stripe pattern.
module led_frame_ctrl #(
  parameter int C_BOARDS       = 1,
  parameter int C_FRAME_PERIOD = 16666,
  parameter int C_BPS          = 12
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_commit,
`ifdef LED_TEST_PATTERN_EN
  input  logic                            i_test,
`endif
  output logic                            o_commit_ack,
  output logic                            o_rd_en,
  output logic                            o_rd_bank,
  output logic [$clog2(C_BOARDS*32)-1:0]  o_rd_addr,
  input  logic [C_BPS-1:0]                i_rd_data,
  output logic                            o_clk,
  output logic                            o_dai,
  output logic                            o_lat,
  output logic                            o_busy,
  output logic                            o_overrun
);

  localparam int CH = C_BOARDS * 32;
  localparam int AW = $clog2(CH);
  localparam int CW = $clog2(C_FRAME_PERIOD);
  localparam int BW = $clog2(C_BPS + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     frame_cnt;
  logic [AW-1:0]     addr;
  logic [AW-1:0]     addr_nx;
  logic [C_BPS-1:0]  shreg;
  logic [C_BPS-1:0]  shreg_nx;
  logic [C_BPS-1:0]  load_val;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     bit_cnt_nx;
  logic              phase;
  logic              phase_nx;
  logic              bank;
  logic              bank_nx;
  logic              pending;
  logic              pending_nx;
  logic              overrun;
  logic              overrun_nx;
  logic              ack_nx;
  logic              frame_start;
  logic              commit_req;

  assign frame_start = (frame_cnt == {CW{1'b0}});
  assign commit_req  = pending | i_commit;
  assign o_rd_addr   = addr;
  assign o_rd_bank   = bank;
  assign o_overrun   = overrun;

`ifdef LED_TEST_PATTERN_EN
  // Test stripes: every fourth channel full on, the rest off.
  always_comb begin
    if (i_test) begin
      if (addr[1:0] == 2'b00) begin
        load_val = {C_BPS{1'b1}};
      end else begin
        load_val = {C_BPS{1'b0}};
      end
    end else begin
      load_val = i_rd_data;
    end
  end
`else
  assign load_val = i_rd_data;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt <= {CW{1'b0}};
    end else if (frame_cnt == CW'(C_FRAME_PERIOD - 1)) begin
      frame_cnt <= {CW{1'b0}};
    end else begin
      frame_cnt <= frame_cnt + CW'(1);
    end
  end

  // Next-state logic; a frame start outside IDLE only raises the overrun flag.
  always_comb begin
    state_nx   = state;
    addr_nx    = addr;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    phase_nx   = phase;
    bank_nx    = bank;
    pending_nx = commit_req;
    overrun_nx = overrun;
    ack_nx     = 1'b0;
    if (frame_start && (state != ST_IDLE)) begin
      overrun_nx = 1'b1;
    end else begin
      overrun_nx = overrun;
    end
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_nx = ST_FETCH;
          addr_nx  = AW'(CH - 1);
          if (commit_req) begin
            bank_nx    = ~bank;
            pending_nx = 1'b0;
            ack_nx     = 1'b1;
          end else begin
            bank_nx = bank;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_nx   = load_val;
        bit_cnt_nx = {BW{1'b0}};
        phase_nx   = 1'b0;
        state_nx   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!phase) begin
          phase_nx = 1'b1;
        end else begin
          phase_nx = 1'b0;
          shreg_nx = {shreg[C_BPS-2:0], 1'b0};
          if (bit_cnt == BW'(C_BPS - 1)) begin
            if (addr != {AW{1'b0}}) begin
              addr_nx  = addr - AW'(1);
              state_nx = ST_FETCH;
            end else begin
              state_nx = ST_LATCH;
            end
          end else begin
            bit_cnt_nx = bit_cnt + BW'(1);
          end
        end
      end
      ST_LATCH: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      addr         <= {AW{1'b0}};
      shreg        <= {C_BPS{1'b0}};
      bit_cnt      <= {BW{1'b0}};
      phase        <= 1'b0;
      bank         <= 1'b0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      o_commit_ack <= 1'b0;
      o_rd_en      <= 1'b0;
      o_clk        <= 1'b0;
      o_dai        <= 1'b0;
      o_lat        <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_nx;
      addr         <= addr_nx;
      shreg        <= shreg_nx;
      bit_cnt      <= bit_cnt_nx;
      phase        <= phase_nx;
      bank         <= bank_nx;
      pending      <= pending_nx;
      overrun      <= overrun_nx;
      o_commit_ack <= ack_nx;
      o_rd_en      <= (state_nx == ST_FETCH);
      o_clk        <= (state_nx == ST_SHIFT) && phase_nx;
      o_dai        <= (state_nx == ST_SHIFT) && shreg_nx[C_BPS-1];
      o_lat        <= (state_nx == ST_LATCH);
      o_busy       <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Scoreboard bench for led_frame_ctrl: stimulus pushes frame events derived from timing rules,
// a negedge monitor pops and compares; a second instance with a short period checks overrun.
module tb_led_frame_ctrl;
  localparam int CH   = 32;
  localparam int BPS  = 12;
  localparam int P    = 16666;
  localparam int P2   = 500;
  localparam int CHL  = 2 + 2 * BPS;
  localparam int FLEN = CH * CHL + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit = 1'b0;
  logic        ack, rd_en, rd_bank, oclk, dai, lat, busy, ovr;
  logic [4:0]  rd_addr;
  logic [11:0] rd_data = 12'h000;
  logic        ack2, rd_en2, rd_bank2, oclk2, dai2, lat2, busy2, ovr2;
  logic [4:0]  rd_addr2;
  logic [11:0] rd_data2 = 12'h000;

  logic [11:0] mem [2][CH];
  int total = 0;
  int bad   = 0;
  int ecnt  = -1;

  int rd_cyc_q[$];
  int rd_addr_q[$];
  int rd_bank_q[$];
  int word_q[$];
  int lat_q[$];
  int ack_q[$];

  led_frame_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_commit(commit), .o_commit_ack(ack),
    .o_rd_en(rd_en), .o_rd_bank(rd_bank), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_clk(oclk), .o_dai(dai), .o_lat(lat), .o_busy(busy), .o_overrun(ovr)
  );

  led_frame_ctrl #(.C_FRAME_PERIOD(P2)) dut_ovr (
    .i_clk(clk), .i_rst(rst), .i_commit(1'b0), .o_commit_ack(ack2),
    .o_rd_en(rd_en2), .o_rd_bank(rd_bank2), .o_rd_addr(rd_addr2), .i_rd_data(rd_data2),
    .o_clk(oclk2), .o_dai(dai2), .o_lat(lat2), .o_busy(busy2), .o_overrun(ovr2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= rst ? -1 : ecnt + 1;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

  always @(posedge clk) begin
    if (rd_en2) rd_data2 <= 12'hA5A;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, ecnt);
    end
  endtask

  // Reference: a frame started at cycle s reads channels CH-1..0 every CHL cycles, latches at s+FLEN-1.
  task automatic push_frame(input int s, input int b);
    for (int k = 0; k < CH; k++) begin
      rd_cyc_q.push_back(s + k * CHL);
      rd_addr_q.push_back(CH - 1 - k);
      rd_bank_q.push_back(b);
      word_q.push_back(int'(mem[b][CH - 1 - k]));
    end
    lat_q.push_back(s + FLEN - 1);
  endtask

  task automatic flush_model();
    rd_cyc_q.delete(); rd_addr_q.delete(); rd_bank_q.delete();
    word_q.delete(); lat_q.delete(); ack_q.delete();
  endtask

  // Monitor: every observed DUT event is matched against the head of its queue.
  initial begin
    int bits, nb, rises;
    logic prev_clk;
    bits = 0; nb = 0; rises = 0; prev_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (ecnt < 0) begin
        bits = 0; nb = 0; rises = 0; prev_clk = 1'b0;
      end else begin
        if (rd_en) begin
          if (rd_cyc_q.size() == 0) begin
            chk("rd_unexpected", 1, 0);
          end else begin
            chk("rd_cycle", ecnt, rd_cyc_q.pop_front());
            chk("rd_addr", int'(rd_addr), rd_addr_q.pop_front());
            chk("rd_bank", int'(rd_bank), rd_bank_q.pop_front());
          end
        end
        if (oclk && !prev_clk) begin
          bits = ((bits << 1) | int'(dai)) & 32'hFFF;
          nb++;
          rises++;
          if (nb == BPS) begin
            if (word_q.size() == 0) chk("word_unexpected", 1, 0);
            else chk("word", bits, word_q.pop_front());
            nb = 0;
            bits = 0;
          end
        end
        prev_clk = oclk;
        if (lat) begin
          if (lat_q.size() == 0) begin
            chk("lat_unexpected", 1, 0);
          end else begin
            chk("lat_cycle", ecnt, lat_q.pop_front());
            chk("clk_rises", rises, CH * BPS);
            chk("lat_clk", int'(oclk), 0);
            chk("lat_dai", int'(dai), 0);
          end
          rises = 0;
        end
        if (ack) begin
          if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
          else chk("ack_cycle", ecnt, ack_q.pop_front());
        end
        if (ecnt % P == 10) chk("busy_in_frame", int'(busy), 1);
        if (ecnt % P == 900) begin
          chk("busy_idle", int'(busy), 0);
          chk("idle_outs", int'({oclk, dai, lat}), 0);
        end
        if (ecnt == P2 - 1) chk("ovr_before", int'(ovr2), 0);
        if (ecnt == P2) chk("ovr_rise", int'(ovr2), 1);
        if (ecnt == 1010) chk("ovr_sticky", int'(ovr2), 1);
        if (ecnt >= 800 && ecnt < 1100) chk("ovr_lat", int'(lat2), int'(ecnt == FLEN - 1));
        if (ecnt == 2 * P2) begin
          chk("ovr_restart_rd", int'(rd_en2), 1);
          chk("ovr_restart_addr", int'(rd_addr2), CH - 1);
        end
      end
    end
  end

  // Stimulus and model: commits set a pending swap that is taken at the next frame start.
  initial begin
    int r1, r2, r3, bank_m;
    bit pend_m;
    for (int a = 0; a < CH; a++) begin
      mem[0][a] = 12'hA5A;
      mem[1][a] = 12'($urandom);
    end
    r1 = $urandom_range(P - 1, 101);
    r2 = $urandom_range(P - 1, 101);
    r3 = P + $urandom_range(P - 1, 1);
    bank_m = 0;
    pend_m = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_outs", int'({ack, rd_en, rd_bank, oclk, dai, lat, busy, ovr}), 0);
    rst = 1'b0;
    for (int c = 0; c < 2 * P + 400; c++) begin
      commit = (c == 100) || (c == r1) || (c == r2) || (c == r3) || (c == 2 * P);
      if (commit) pend_m = 1'b1;
      if (c % P == 0) begin
        if (pend_m) begin
          bank_m ^= 1;
          pend_m = 1'b0;
          ack_q.push_back(c);
        end
        push_frame(c, bank_m);
      end
      @(negedge clk);
    end
    commit = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    flush_model();
    chk("midrst_outs", int'({oclk, dai, lat, busy, rd_en, rd_bank}), 0);
    rst = 1'b0;
    bank_m = 0;
    for (int c = 0; c < FLEN + 40; c++) begin
      if (c == 0) push_frame(c, bank_m);
      @(negedge clk);
    end
    chk("left_rd", rd_cyc_q.size(), 0);
    chk("left_word", word_q.size(), 0);
    chk("left_lat", lat_q.size(), 0);
    chk("left_ack", ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
